// File: rtl/ibex_rvfi_trace_fifo.sv
// Captures RVFI retirements into a record FIFO streamed over valid/ready.
// Overflow drops are counted and the first record after a loss carries gap=1.
module ibex_rvfi_trace_fifo #(
   parameter int unsigned Depth        = 16,
   parameter int unsigned DropCntWidth = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            enable_i,
   input  logic                            flush_i,
   input  logic                            rvfi_valid,
   input  logic [31:0]                     rvfi_pc_rdata,
   input  logic [31:0]                     rvfi_insn,
   input  logic [4:0]                      rvfi_rd_addr,
   input  logic [31:0]                     rvfi_rd_wdata,
   input  logic                            rvfi_trap,
   input  logic                            rvfi_intr,
   input  logic [1:0]                      rvfi_mode,
   output logic                            trace_valid_o,
   input  logic                            trace_ready_i,
   output logic [105:0]                    trace_data_o,
   output logic [$clog2(Depth):0]          level_o,
   output logic [DropCntWidth-1:0]         drop_cnt_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned LvlW = PtrW + 1;
   localparam int unsigned RecW = 106;

   logic [RecW-1:0]         mem_q [Depth];
   logic [PtrW-1:0]         wptr_q, wptr_d;
   logic [PtrW-1:0]         rptr_q, rptr_d;
   logic [LvlW-1:0]         level_q, level_d;
   logic                    gap_q, gap_d;
   logic [DropCntWidth-1:0] drop_q, drop_d;

   logic            push_req, pop, full, push_acc, drop;
   logic [RecW-1:0] rec;

   // Record packing; x0 writes carry no meaningful data so they are zeroed.
   always_comb begin
      rec = {gap_q, rvfi_mode, rvfi_intr, rvfi_trap, rvfi_rd_addr,
             (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata,
             rvfi_insn, rvfi_pc_rdata};
   end

   // A full FIFO can still accept when the head leaves in the same cycle.
   always_comb begin
      full     = (level_q == LvlW'(Depth));
      push_req = enable_i & rvfi_valid & ~flush_i;
      pop      = trace_valid_o & trace_ready_i & ~flush_i;
      push_acc = push_req & (~full | pop);
      drop     = push_req & full & ~pop;
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      gap_d   = gap_q;
      drop_d  = drop_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
         gap_d   = 1'b0;
         drop_d  = '0;
      end else begin
         if (push_acc) begin
            wptr_d = wptr_q + PtrW'(1);
            gap_d  = 1'b0;
         end
         if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
         end
         if (push_acc && !pop) begin
            level_d = level_q + LvlW'(1);
         end else if (pop && !push_acc) begin
            level_d = level_q - LvlW'(1);
         end
         if (drop) begin
            gap_d = 1'b1;
            if (drop_q != {DropCntWidth{1'b1}}) begin
               drop_d = drop_q + DropCntWidth'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         gap_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         gap_q   <= gap_d;
         drop_q  <= drop_d;
         if (push_acc) begin
            mem_q[wptr_q] <= rec;
         end
      end
   end

   // Memory contents are never exposed while empty, so storage needs no reset.
   assign trace_valid_o = (level_q != '0);
   assign trace_data_o  = trace_valid_o ? mem_q[rptr_q] : '0;
   assign level_o       = level_q;
   assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_fifo.sv
// Bench for ibex_rvfi_trace_fifo: vector table, directed corner sequences and
// randomized traffic checked against a queue-based record model.
module tb_ibex_rvfi_trace_fifo;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned DCW    = 16;
   localparam int unsigned DCMAX  = 65535;

   logic         clk = 1'b0;
   logic         rst_n, en, flush, valid, ready;
   logic [31:0]  pc, insn, wdata;
   logic [4:0]   rd;
   logic         trap, intr;
   logic [1:0]   mode;
   logic         trace_valid;
   logic [105:0] trace_data;
   logic [4:0]   level;
   logic [DCW-1:0] drop_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [105:0] mq[$];
   int unsigned  m_drop;
   bit           m_gap;

   always #5 clk = ~clk;

   ibex_rvfi_trace_fifo #(.Depth(DEPTH), .DropCntWidth(DCW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .flush_i(flush),
      .rvfi_valid(valid), .rvfi_pc_rdata(pc), .rvfi_insn(insn),
      .rvfi_rd_addr(rd), .rvfi_rd_wdata(wdata), .rvfi_trap(trap),
      .rvfi_intr(intr), .rvfi_mode(mode),
      .trace_valid_o(trace_valid), .trace_ready_i(ready),
      .trace_data_o(trace_data), .level_o(level), .drop_cnt_o(drop_cnt)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [105:0] mk_rec(input bit g);
      logic [31:0] wd;
      wd = (rd == 5'd0) ? 32'd0 : wdata;
      return {g, mode, intr, trap, rd, wd, insn, pc};
   endfunction

   task automatic set_ret(input logic v, input logic [31:0] p);
      valid = v; pc = p; insn = p ^ 32'h0000_0013; rd = 5'd1;
      wdata = p + 32'd1; trap = 1'b0; intr = 1'b0; mode = 2'd3;
   endtask

   // Advance one clock, updating the model from the applied inputs, then compare.
   task automatic step();
      bit popped;
      if (!rst_n || flush) begin
         mq.delete(); m_drop = 0; m_gap = 1'b0;
      end else begin
         popped = (mq.size() != 0) && ready;
         if (popped) void'(mq.pop_front());
         if (en && valid) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(mk_rec(m_gap));
               m_gap = 1'b0;
            end else begin
               if (m_drop < DCMAX) m_drop++;
               m_gap = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      check("m_level", 128'(level), 128'(mq.size()));
      check("m_valid", 128'(trace_valid), 128'(mq.size() != 0));
      check("m_data",  128'(trace_data), (mq.size() != 0) ? 128'(mq[0]) : 128'd0);
      check("m_drop",  128'(drop_cnt), 128'(m_drop));
   endtask

   typedef struct {
      logic        v;
      logic [31:0] p;
      logic        rdy;
      int unsigned exp_level;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int unsigned seen_gap;
      int unsigned rdy_pct;

      tbl[0] = '{1'b1, 32'h100, 1'b0, 1, 1'b1, 32'h100};
      tbl[1] = '{1'b1, 32'h104, 1'b0, 2, 1'b1, 32'h100};
      tbl[2] = '{1'b1, 32'h108, 1'b0, 3, 1'b1, 32'h100};
      tbl[3] = '{1'b0, 32'h0,   1'b1, 2, 1'b1, 32'h104};
      tbl[4] = '{1'b0, 32'h0,   1'b1, 1, 1'b1, 32'h108};
      tbl[5] = '{1'b0, 32'h0,   1'b1, 0, 1'b0, 32'h0};

      rst_n = 1'b0; en = 1'b1; flush = 1'b0; ready = 1'b0;
      set_ret(1'b1, 32'h40);
      step(); step();
      check("rst_valid", 128'(trace_valid), 128'd0);
      check("rst_level", 128'(level), 128'd0);
      check("rst_drop",  128'(drop_cnt), 128'd0);
      check("rst_data",  128'(trace_data), 128'd0);
      rst_n = 1'b1;

      // Basic ordering and latency
      foreach (tbl[i]) begin
         set_ret(tbl[i].v, tbl[i].p);
         ready = tbl[i].rdy;
         step();
         check("tbl_level", 128'(level), 128'(tbl[i].exp_level));
         check("tbl_valid", 128'(trace_valid), 128'(tbl[i].exp_valid));
         check("tbl_pc",    128'(trace_data[31:0]), 128'(tbl[i].exp_pc));
         check("tbl_gap",   128'(trace_data[105]), 128'd0);
      end

      // Field packing with x0 destination
      ready = 1'b0;
      set_ret(1'b1, 32'h300);
      rd = 5'd0; wdata = 32'hDEAD_BEEF; trap = 1'b1; mode = 2'd3;
      step();
      valid = 1'b0;
      check("pack_wdata", 128'(trace_data[95:64]), 128'd0);
      check("pack_rd",    128'(trace_data[100:96]), 128'd0);
      check("pack_trap",  128'(trace_data[101]), 128'd1);
      check("pack_mode",  128'(trace_data[104:103]), 128'd3);
      check("pack_insn",  128'(trace_data[63:32]), 128'h0000_0313);
      ready = 1'b1; step();

      // Overflow, drop count and gap marking
      flush = 1'b1; step(); flush = 1'b0;
      ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         set_ret(1'b1, 32'h1000 + 32'(4 * i));
         step();
      end
      check("ovf_level", 128'(level), 128'd16);
      check("ovf_drop",  128'(drop_cnt), 128'd4);
      check("ovf_head_gap", 128'(trace_data[105]), 128'd0);
      ready = 1'b1;
      set_ret(1'b1, 32'h200);
      step();
      check("ovf_full_pop_level", 128'(level), 128'd16);
      valid = 1'b0;
      seen_gap = 0;
      for (int i = 0; i < 16; i++) begin
         check("drain_pc",  128'(trace_data[31:0]),
               (i < 15) ? 128'(32'h1004 + 32'(4 * i)) : 128'h200);
         check("drain_gap", 128'(trace_data[105]), (i == 15) ? 128'd1 : 128'd0);
         seen_gap += 32'(trace_data[105]);
         step();
      end
      check("drain_gap_count", 128'(seen_gap), 128'd1);
      check("drain_empty", 128'(trace_valid), 128'd0);

      // Full with simultaneous push and pop is not a drop
      flush = 1'b1; step(); flush = 1'b0;
      ready = 1'b0;
      for (int i = 0; i < 16; i++) begin set_ret(1'b1, 32'h2000 + 32'(4 * i)); step(); end
      ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_ret(1'b1, 32'h3000 + 32'(4 * i));
         step();
         check("fullpp_level", 128'(level), 128'd16);
         check("fullpp_drop",  128'(drop_cnt), 128'd0);
      end

      // Drop counter saturation, then flush with coincident retirement
      ready = 1'b0;
      set_ret(1'b1, 32'h4000);
      for (int i = 0; i < 70000; i++) step();
      check("sat_drop", 128'(drop_cnt), 128'hFFFF);
      step(); step();
      check("sat_hold", 128'(drop_cnt), 128'hFFFF);
      flush = 1'b1; set_ret(1'b1, 32'h5000); ready = 1'b1;
      step();
      flush = 1'b0; valid = 1'b0;
      check("flush_level", 128'(level), 128'd0);
      check("flush_drop",  128'(drop_cnt), 128'd0);
      check("flush_valid", 128'(trace_valid), 128'd0);
      step();
      check("flush_not_stored", 128'(level), 128'd0);

      // Capture disabled, then reset mid-drain
      en = 1'b0; ready = 1'b0;
      for (int i = 0; i < 5; i++) begin set_ret(1'b1, 32'h6000 + 32'(4 * i)); step(); end
      check("dis_level", 128'(level), 128'd0);
      check("dis_drop",  128'(drop_cnt), 128'd0);
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin set_ret(1'b1, 32'h7000 + 32'(4 * i)); step(); end
      check("pre_rst_level", 128'(level), 128'd5);
      valid = 1'b0; ready = 1'b1;
      rst_n = 1'b0;
      step();
      check("mid_rst_valid", 128'(trace_valid), 128'd0);
      check("mid_rst_level", 128'(level), 128'd0);
      check("mid_rst_drop",  128'(drop_cnt), 128'd0);
      check("mid_rst_data",  128'(trace_data), 128'd0);
      rst_n = 1'b1;

      // Randomized traffic against the model
      rdy_pct = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            case ($urandom_range(0, 2))
               0: rdy_pct = 15;
               1: rdy_pct = 50;
               default: rdy_pct = 95;
            endcase
         end
         valid = ($urandom_range(0, 99) < 70);
         ready = ($urandom_range(0, 99) < rdy_pct);
         en    = ($urandom_range(0, 99) < 95);
         flush = ($urandom_range(0, 99) < 2);
         rst_n = ($urandom_range(0, 399) != 0);
         pc    = $urandom; insn = $urandom; wdata = $urandom;
         rd    = 5'($urandom_range(0, 31));
         trap  = 1'($urandom_range(0, 1));
         intr  = 1'($urandom_range(0, 1));
         mode  = 2'($urandom_range(0, 3));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
